// File: rtl/mem_exec_unit.sv
// Memory execute stage: issues one load/store per packet to the data-memory
// port, aligns and extends load data, and reports completion on a CDB output.
module mem_exec_unit #(
    parameter int PHYS_WIDTH     = 6,
    parameter int ROB_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      br_flush,
    input  logic                      pkt_valid,
    input  logic                      pkt_is_store,
    input  logic [2:0]                pkt_funct3,
    input  logic [31:0]               pkt_rs1_data,
    input  logic [31:0]               pkt_rs2_data,
    input  logic [31:0]               pkt_imm,
    input  logic [PHYS_WIDTH-1:0]     pkt_rd_paddr,
    input  logic [ROB_ADDR_WIDTH-1:0] pkt_rob_idx,
    output logic                      stall_mem,
    output logic [31:0]               dmem_addr,
    output logic [3:0]                dmem_rmask,
    output logic [3:0]                dmem_wmask,
    output logic [31:0]               dmem_wdata,
    input  logic [31:0]               dmem_rdata,
    input  logic                      dmem_resp,
    output logic                      cdb_valid,
    output logic [PHYS_WIDTH-1:0]     cdb_rd_paddr,
    output logic [ROB_ADDR_WIDTH-1:0] cdb_rob_idx,
    output logic [31:0]               cdb_data,
    output logic                      cdb_is_store
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t                    state;
    logic [31:0]               ea;
    logic [31:0]               st_data;
    logic [3:0]                lane_mask;
    logic                      legal;
    logic                      is_store_q;
    logic                      legal_q;
    logic [2:0]                funct3_q;
    logic [1:0]                ea_lo_q;
    logic [PHYS_WIDTH-1:0]     rd_q;
    logic [ROB_ADDR_WIDTH-1:0] rob_q;
    logic                      cdb_valid_q;
    logic [7:0]                byte_src;
    logic [15:0]               half_src;
    logic [31:0]               ld_data;

    always_comb begin
        ea        = pkt_rs1_data + pkt_imm;
        lane_mask = '0;
        st_data   = '0;
        legal     = 1'b0;
        case (pkt_funct3)
            3'b000: begin
                legal     = 1'b1;
                lane_mask = 4'b0001 << ea[1:0];
                st_data   = {24'h0, pkt_rs2_data[7:0]} << {ea[1:0], 3'b000};
            end
            3'b001: begin
                legal     = 1'b1;
                lane_mask = 4'b0011 << ea[1:0];
                st_data   = {16'h0, pkt_rs2_data[15:0]} << {ea[1], 4'b0000};
            end
            3'b010: begin
                legal     = 1'b1;
                lane_mask = 4'b1111;
                st_data   = pkt_rs2_data;
            end
            3'b100:  begin legal = !pkt_is_store; lane_mask = 4'b0001 << ea[1:0]; end
            3'b101:  begin legal = !pkt_is_store; lane_mask = 4'b0011 << ea[1:0]; end
            default: legal = 1'b0;
        endcase
        if (!legal) lane_mask = '0;
    end

    always_comb begin
        byte_src = 8'(dmem_rdata >> {ea_lo_q, 3'b000});
        half_src = 16'(dmem_rdata >> {ea_lo_q[1], 4'b0000});
        case (funct3_q)
            3'b000:  ld_data = {{24{byte_src[7]}}, byte_src};
            3'b100:  ld_data = {24'h0, byte_src};
            3'b001:  ld_data = {{16{half_src[15]}}, half_src};
            3'b101:  ld_data = {16'h0, half_src};
            3'b010:  ld_data = dmem_rdata;
            default: ld_data = '0;
        endcase
    end

    assign stall_mem = (state != S_IDLE);
    // A flush also kills a completion already sitting on the CDB this cycle.
    assign cdb_valid = cdb_valid_q && !br_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            is_store_q   <= 1'b0;
            legal_q      <= 1'b0;
            funct3_q     <= '0;
            ea_lo_q      <= '0;
            rd_q         <= '0;
            rob_q        <= '0;
            dmem_addr    <= '0;
            dmem_rmask   <= '0;
            dmem_wmask   <= '0;
            dmem_wdata   <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_rd_paddr <= '0;
            cdb_rob_idx  <= '0;
            cdb_data     <= '0;
            cdb_is_store <= 1'b0;
        end else begin
            dmem_addr    <= '0;
            dmem_rmask   <= '0;
            dmem_wmask   <= '0;
            dmem_wdata   <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_rd_paddr <= '0;
            cdb_rob_idx  <= '0;
            cdb_data     <= '0;
            cdb_is_store <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pkt_valid && !br_flush) begin
                        is_store_q <= pkt_is_store;
                        legal_q    <= legal;
                        funct3_q   <= pkt_funct3;
                        ea_lo_q    <= ea[1:0];
                        rd_q       <= pkt_rd_paddr;
                        rob_q      <= pkt_rob_idx;
                        if (legal) begin
                            dmem_addr <= {ea[31:2], 2'b00};
                            if (pkt_is_store) begin
                                dmem_wmask <= lane_mask;
                                dmem_wdata <= st_data;
                            end else begin
                                dmem_rmask <= lane_mask;
                            end
                        end
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!legal_q) begin
                        state <= S_IDLE;
                        if (!br_flush) begin
                            cdb_valid_q  <= 1'b1;
                            cdb_rd_paddr <= is_store_q ? '0 : rd_q;
                            cdb_rob_idx  <= rob_q;
                            cdb_is_store <= is_store_q;
                        end
                    end else begin
                        state <= br_flush ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_resp) begin
                        state <= S_IDLE;
                        if (!br_flush) begin
                            cdb_valid_q  <= 1'b1;
                            cdb_rd_paddr <= is_store_q ? '0 : rd_q;
                            cdb_rob_idx  <= rob_q;
                            cdb_data     <= is_store_q ? '0 : ld_data;
                            cdb_is_store <= is_store_q;
                        end
                    end else if (br_flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dmem_resp) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_exec_unit.sv
// Directed self-checking bench for mem_exec_unit.
module tb_mem_exec_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        br_flush = 1'b0;
    logic        pkt_valid = 1'b0;
    logic        pkt_is_store = 1'b0;
    logic [2:0]  pkt_funct3 = '0;
    logic [31:0] pkt_rs1_data = '0;
    logic [31:0] pkt_rs2_data = '0;
    logic [31:0] pkt_imm = '0;
    logic [5:0]  pkt_rd_paddr = '0;
    logic [3:0]  pkt_rob_idx = '0;
    logic        stall_mem;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_resp = 1'b0;
    logic        cdb_valid;
    logic [5:0]  cdb_rd_paddr;
    logic [3:0]  cdb_rob_idx;
    logic [31:0] cdb_data;
    logic        cdb_is_store;

    int total = 0;
    int bad = 0;

    mem_exec_unit #(.PHYS_WIDTH(6), .ROB_ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .br_flush(br_flush),
        .pkt_valid(pkt_valid), .pkt_is_store(pkt_is_store), .pkt_funct3(pkt_funct3),
        .pkt_rs1_data(pkt_rs1_data), .pkt_rs2_data(pkt_rs2_data), .pkt_imm(pkt_imm),
        .pkt_rd_paddr(pkt_rd_paddr), .pkt_rob_idx(pkt_rob_idx),
        .stall_mem(stall_mem), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .cdb_valid(cdb_valid), .cdb_rd_paddr(cdb_rd_paddr),
        .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data), .cdb_is_store(cdb_is_store)
    );

    always #5 clk = ~clk;

    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] imm, input logic [31:0] rs2,
                        input logic [5:0] rd, input logic [3:0] rob);
        pkt_valid = 1'b1; pkt_is_store = st; pkt_funct3 = f3; pkt_rs1_data = rs1;
        pkt_imm = imm; pkt_rs2_data = rs2; pkt_rd_paddr = rd; pkt_rob_idx = rob;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({stall_mem, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, cdb_valid,
             cdb_rd_paddr, cdb_rob_idx, cdb_data, cdb_is_store} !== '0) begin
            bad++; $display("FAIL reset_outputs: got stall=%b addr=%h cdb_valid=%b exp all zero",
                            stall_mem, dmem_addr, cdb_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] rs1,
                             input logic [31:0] imm, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                             input logic [31:0] exp_data, input logic [3:0] rob, input int k);
        send(1'b0, f3, rs1, imm, 32'h0, 6'h15, rob);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        total++;
        if (dmem_addr !== exp_addr) begin
            bad++; $display("FAIL %s addr: got %h exp %h", name, dmem_addr, exp_addr);
        end
        total++;
        if ({dmem_rmask, dmem_wmask, stall_mem} !== {exp_mask, 4'h0, 1'b1}) begin
            bad++; $display("FAIL %s req_masks: got r=%b w=%b stall=%b exp r=%b w=0000 stall=1",
                            name, dmem_rmask, dmem_wmask, stall_mem, exp_mask);
        end
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            total++;
            if ({stall_mem, dmem_addr, dmem_rmask, cdb_valid} !== {1'b1, 32'h0, 4'h0, 1'b0}) begin
                bad++; $display("FAIL %s wait: got stall=%b addr=%h rmask=%b cdb_valid=%b exp 1/0/0/0",
                                name, stall_mem, dmem_addr, dmem_rmask, cdb_valid);
            end
        end
        dmem_resp = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = '0;
        total++;
        if ({cdb_valid, stall_mem} !== 2'b10) begin
            bad++; $display("FAIL %s cdb_pulse: got valid=%b stall=%b exp 1/0", name, cdb_valid, stall_mem);
        end
        total++;
        if (cdb_data !== exp_data) begin
            bad++; $display("FAIL %s cdb_data: got %h exp %h", name, cdb_data, exp_data);
        end
        total++;
        if ({cdb_is_store, cdb_rd_paddr, cdb_rob_idx} !== {1'b0, 6'h15, rob}) begin
            bad++; $display("FAIL %s cdb_tag: got st=%b rd=%h rob=%h exp 0/15/%h",
                            name, cdb_is_store, cdb_rd_paddr, cdb_rob_idx, rob);
        end
        @(posedge clk); #1;
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++; $display("FAIL %s cdb_one_cycle: got %b exp 0", name, cdb_valid);
        end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] rs1,
                              input logic [31:0] imm, input logic [31:0] rs2,
                              input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                              input logic [31:0] exp_wdata, input logic [3:0] rob);
        send(1'b1, f3, rs1, imm, rs2, 6'h2A, rob);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        total++;
        if ({dmem_addr, dmem_wmask, dmem_rmask} !== {exp_addr, exp_mask, 4'h0}) begin
            bad++; $display("FAIL %s req: got addr=%h w=%b r=%b exp addr=%h w=%b r=0000",
                            name, dmem_addr, dmem_wmask, dmem_rmask, exp_addr, exp_mask);
        end
        total++;
        if (dmem_wdata !== exp_wdata) begin
            bad++; $display("FAIL %s wdata: got %h exp %h", name, dmem_wdata, exp_wdata);
        end
        @(posedge clk); #1;
        total++;
        if ({dmem_wmask, dmem_wdata} !== 36'h0) begin
            bad++; $display("FAIL %s wait_clear: got w=%b wdata=%h exp 0", name, dmem_wmask, dmem_wdata);
        end
        dmem_resp = 1'b1;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        total++;
        if ({cdb_valid, cdb_is_store, cdb_data, cdb_rd_paddr, cdb_rob_idx} !==
            {1'b1, 1'b1, 32'h0, 6'h0, rob}) begin
            bad++; $display("FAIL %s cdb: got v=%b st=%b data=%h rd=%h rob=%h exp 1/1/0/0/%h",
                            name, cdb_valid, cdb_is_store, cdb_data, cdb_rd_paddr, cdb_rob_idx, rob);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        send(1'b0, 3'b011, 32'h404, 32'h0, 32'h0, 6'h09, 4'h9);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        total++;
        if ({dmem_rmask, dmem_wmask, stall_mem} !== 9'b0000_0000_1) begin
            bad++; $display("FAIL illegal_req: got r=%b w=%b stall=%b exp 0/0/1", dmem_rmask, dmem_wmask, stall_mem);
        end
        @(posedge clk); #1;
        total++;
        if ({cdb_valid, stall_mem, cdb_data, cdb_rob_idx, cdb_rd_paddr} !== {2'b10, 32'h0, 4'h9, 6'h09}) begin
            bad++; $display("FAIL illegal_cdb: got v=%b stall=%b data=%h rob=%h rd=%h exp 1/0/0/9/09",
                            cdb_valid, stall_mem, cdb_data, cdb_rob_idx, cdb_rd_paddr);
        end
        send(1'b1, 3'b100, 32'h500, 32'h0, 32'hFFFF_FFFF, 6'h01, 4'hA);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        total++;
        if ({dmem_wmask, dmem_wdata} !== 36'h0) begin
            bad++; $display("FAIL illegal_store_req: got w=%b wdata=%h exp 0", dmem_wmask, dmem_wdata);
        end
        @(posedge clk); #1;
        total++;
        if ({cdb_valid, cdb_is_store, cdb_data} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL illegal_store_cdb: got v=%b st=%b data=%h exp 1/1/0", cdb_valid, cdb_is_store, cdb_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_wait();
        send(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 6'h03, 4'h5);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        @(posedge clk); #1;
        br_flush = 1'b1;
        @(posedge clk); #1;
        br_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({stall_mem, cdb_valid} !== 2'b10) begin
                bad++; $display("FAIL flush_wait_drain: got stall=%b cdb_valid=%b exp 1/0", stall_mem, cdb_valid);
            end
            if (i < 2) begin @(posedge clk); #1; end
        end
        dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = '0;
        total++;
        if ({cdb_valid, stall_mem} !== 2'b00) begin
            bad++; $display("FAIL flush_wait_resp: got cdb_valid=%b stall=%b exp 0/0", cdb_valid, stall_mem);
        end
        send(1'b0, 3'b010, 32'h50, 32'h0, 32'h0, 6'h04, 4'h6);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        total++;
        if ({stall_mem, dmem_addr, dmem_rmask} !== {1'b1, 32'h50, 4'hF}) begin
            bad++; $display("FAIL flush_next_accept: got stall=%b addr=%h r=%b exp 1/00000050/1111",
                            stall_mem, dmem_addr, dmem_rmask);
        end
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = '0;
        total++;
        if ({cdb_valid, cdb_data, cdb_rob_idx} !== {1'b1, 32'hA5A5_A5A5, 4'h6}) begin
            bad++; $display("FAIL flush_next_cdb: got v=%b data=%h rob=%h exp 1/a5a5a5a5/6",
                            cdb_valid, cdb_data, cdb_rob_idx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_misc();
        send(1'b0, 3'b010, 32'h44, 32'h0, 32'h0, 6'h05, 4'h1);
        br_flush = 1'b1;
        @(posedge clk); #1;
        pkt_valid = 1'b0; br_flush = 1'b0;
        total++;
        if ({stall_mem, dmem_rmask} !== 5'b0) begin
            bad++; $display("FAIL flush_idle: got stall=%b r=%b exp 0/0000", stall_mem, dmem_rmask);
        end
        send(1'b0, 3'b010, 32'h60, 32'h0, 32'h0, 6'h05, 4'h2);
        @(posedge clk); #1;
        pkt_valid = 1'b0; br_flush = 1'b1;
        #1;
        total++;
        if ({dmem_addr, dmem_rmask} !== {32'h60, 4'hF}) begin
            bad++; $display("FAIL flush_req_issue: got addr=%h r=%b exp 00000060/1111", dmem_addr, dmem_rmask);
        end
        @(posedge clk); #1;
        br_flush = 1'b0;
        total++;
        if ({stall_mem, dmem_rmask} !== 5'b1_0000) begin
            bad++; $display("FAIL flush_req_drain: got stall=%b r=%b exp 1/0000", stall_mem, dmem_rmask);
        end
        dmem_resp = 1'b1;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        total++;
        if ({cdb_valid, stall_mem} !== 2'b00) begin
            bad++; $display("FAIL flush_req_resp: got cdb_valid=%b stall=%b exp 0/0", cdb_valid, stall_mem);
        end
        send(1'b0, 3'b010, 32'h70, 32'h0, 32'h0, 6'h05, 4'h3);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        @(posedge clk); #1;
        br_flush = 1'b1; dmem_resp = 1'b1;
        @(posedge clk); #1;
        br_flush = 1'b0; dmem_resp = 1'b0;
        total++;
        if ({cdb_valid, stall_mem} !== 2'b00) begin
            bad++; $display("FAIL flush_same_cycle: got cdb_valid=%b stall=%b exp 0/0", cdb_valid, stall_mem);
        end
        send(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 6'h05, 4'h4);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'h11;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = '0;
        total++;
        if (cdb_valid !== 1'b1) begin
            bad++; $display("FAIL flush_cdb_pre: got %b exp 1", cdb_valid);
        end
        br_flush = 1'b1;
        #1;
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++; $display("FAIL flush_cdb_kill: got %b exp 0", cdb_valid);
        end
        @(posedge clk); #1;
        br_flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        send(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 6'h07, 4'h1);
        @(posedge clk); #1;
        total++;
        if ({stall_mem, dmem_addr} !== {1'b1, 32'h100}) begin
            bad++; $display("FAIL b2b_first_req: got stall=%b addr=%h exp 1/00000100", stall_mem, dmem_addr);
        end
        send(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 6'h08, 4'h2);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if ({stall_mem, dmem_addr, dmem_rmask} !== {1'b1, 32'h0, 4'h0}) begin
                bad++; $display("FAIL b2b_hold: got stall=%b addr=%h r=%b exp 1/0/0", stall_mem, dmem_addr, dmem_rmask);
            end
        end
        dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = '0;
        total++;
        if ({cdb_valid, stall_mem, cdb_rob_idx, cdb_data} !== {2'b10, 4'h1, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL b2b_first_cdb: got v=%b stall=%b rob=%h data=%h exp 1/0/1/cafef00d",
                            cdb_valid, stall_mem, cdb_rob_idx, cdb_data);
        end
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        total++;
        if ({stall_mem, dmem_addr, cdb_valid} !== {1'b1, 32'h200, 1'b0}) begin
            bad++; $display("FAIL b2b_second_accept: got stall=%b addr=%h cdb_valid=%b exp 1/00000200/0",
                            stall_mem, dmem_addr, cdb_valid);
        end
        @(posedge clk); #1;
        dmem_resp = 1'b1; dmem_rdata = 32'h2;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = '0;
        total++;
        if ({cdb_valid, cdb_rob_idx, cdb_data} !== {1'b1, 4'h2, 32'h2}) begin
            bad++; $display("FAIL b2b_second_cdb: got v=%b rob=%h data=%h exp 1/2/00000002",
                            cdb_valid, cdb_rob_idx, cdb_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        send(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 6'h0B, 4'hC);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (stall_mem !== 1'b1) begin
            bad++; $display("FAIL areset_pre: got stall=%b exp 1", stall_mem);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({stall_mem, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, cdb_valid,
             cdb_rd_paddr, cdb_rob_idx, cdb_data, cdb_is_store} !== '0) begin
            bad++; $display("FAIL areset_outputs: got stall=%b addr=%h r=%b cdb_valid=%b exp all zero",
                            stall_mem, dmem_addr, dmem_rmask, cdb_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_resp = 1'b0; dmem_rdata = '0;
        @(posedge clk); #1;
        total++;
        if ({cdb_valid, stall_mem} !== 2'b00) begin
            bad++; $display("FAIL areset_late_resp: got cdb_valid=%b stall=%b exp 0/0", cdb_valid, stall_mem);
        end
    endtask

    initial begin
        test_reset();
        test_load("lw",      3'b010, 32'h1000,     32'h4,        32'hDEAD_BEEF, 32'h1004, 4'b1111, 32'hDEAD_BEEF, 4'h1, 2);
        test_load("lb",      3'b000, 32'h2003,     32'h0,        32'h8012_3456, 32'h2000, 4'b1000, 32'hFFFF_FF80, 4'h2, 1);
        test_load("lbu",     3'b100, 32'h2003,     32'h0,        32'h8012_3456, 32'h2000, 4'b1000, 32'h0000_0080, 4'h3, 1);
        test_load("lh",      3'b001, 32'h10,       32'hFFFF_FFFE, 32'h8001_7FFF, 32'h000C, 4'b1100, 32'hFFFF_8001, 4'h4, 1);
        test_load("lhu",     3'b101, 32'h4000,     32'h0,        32'h1234_F00D, 32'h4000, 4'b0011, 32'h0000_F00D, 4'h5, 3);
        test_load("lh_edge", 3'b001, 32'h5003,     32'h0,        32'hC0DE_0000, 32'h5000, 4'b1000, 32'hFFFF_C0DE, 4'h6, 1);
        test_load("lw_wrap", 3'b010, 32'hFFFF_FFFC, 32'h8,       32'h0000_0001, 32'h0004, 4'b1111, 32'h0000_0001, 4'h7, 1);
        test_store("sh", 3'b001, 32'h3000, 32'h2,         32'h1234_ABCD, 32'h3000, 4'b1100, 32'hABCD_0000, 4'h8);
        test_store("sb", 3'b000, 32'h3001, 32'h0,         32'h1234_ABCD, 32'h3000, 4'b0010, 32'h0000_CD00, 4'h9);
        test_store("sw", 3'b010, 32'h3100, 32'hFFFF_FFFC, 32'h1234_ABCD, 32'h30FC, 4'b1111, 32'h1234_ABCD, 4'hA);
        test_illegal();
        test_flush_wait();
        test_flush_misc();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_exec_unit.md
Name: mem_exec_unit

Overview:
- Memory execute stage directly downstream of the load/store queue.
- Accepts one load or store packet at a time, computes the effective address and byte masks, and issues a single request on the data-memory port.
- Waits for the memory response, then aligns and sign/zero-extends load data.
- Broadcasts the result on a registered CDB-style output. While busy it asserts stall_mem back to the queue.

Parameters:
PHYS_WIDTH, 6, physical register address width
ROB_ADDR_WIDTH, 4, ROB index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
br_flush  in  1  squash in-flight work (synchronous)
pkt_valid  in  1  packet present from LSQ
pkt_is_store  in  1  1 = store, 0 = load
pkt_funct3  in  3  RV32I load/store funct3
pkt_rs1_data  in  32  base register value
pkt_rs2_data  in  32  store data
pkt_imm  in  32  sign-extended offset
pkt_rd_paddr  in  PHYS_WIDTH  load destination
pkt_rob_idx  in  ROB_ADDR_WIDTH  ROB entry
stall_mem  out  1  unit busy; upstream must hold its packet
dmem_addr  out  32  word-aligned address
dmem_rmask  out  4  read byte mask
dmem_wmask  out  4  write byte mask
dmem_wdata  out  32  lane-shifted write data
dmem_rdata  in  32  read data
dmem_resp  in  1  response strobe
cdb_valid  out  1  result valid, one-cycle pulse
cdb_rd_paddr  out  PHYS_WIDTH  destination (0 for stores)
cdb_rob_idx  out  ROB_ADDR_WIDTH  ROB entry
cdb_data  out  32  load result (0 for stores)
cdb_is_store  out  1  completion is a store

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 (stall_mem=0, masks=0, dmem_addr=0, dmem_wdata=0, cdb_*=0).
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: stall_mem=0. If pkt_valid && !br_flush, capture the packet, compute ea = rs1 + imm (32-bit wrap), and go to REQ.
- REQ:
  - dmem_addr = {ea[31:2],2'b00}.
  - Masks for exactly this one cycle: byte = 4'b0001<<ea[1:0]; half = 4'b0011<<ea[1:0]; word = 4'b1111. Bits shifted past 4 are dropped.
  - Only one of rmask/wmask is nonzero.
  - Store data: sb places rs2[7:0] at byte ea[1:0]; sh places rs2[15:0] at 16*ea[1]; sw places all 32 bits. Unused lanes are 0.
  - Next state is WAIT.
- WAIT: dmem_addr, wdata and masks return to 0. On dmem_resp, go to IDLE and register the CDB outputs for the next cycle.
- Load extension: lb/lbu extract byte ea[1:0] with sign/zero extension; lh/lhu extract halfword ea[1] with sign/zero extension; lw passes data through.
- stall_mem = (state != IDLE).
- Latency: accept at cycle T, request at T+1, response at T+1+k (k≥1), cdb_valid at T+2+k. Minimum occupancy is 3 cycles.
- cdb_valid pulses for one cycle. Stores also pulse, with cdb_is_store=1 and cdb_data=0.
- Illegal funct3: masks are 0, no memory request is issued, and the unit goes from REQ straight to IDLE with a CDB completion (data 0).
- br_flush:
  - In IDLE: the packet is not accepted.
  - In REQ: the request is still issued (it is already committed to the port), then the unit goes to DRAIN.
  - In WAIT with no dmem_resp: go to DRAIN.
  - In WAIT with dmem_resp in the same cycle: go to IDLE with no CDB pulse.
  - On the cycle it is asserted: any CDB output pending from the previous response is cleared (cdb_valid forced 0).
- DRAIN: stall_mem stays 1. On dmem_resp, go to IDLE with no CDB pulse. A new flush while in DRAIN has no further effect.
- A packet presented while stall_mem=1 is ignored; upstream is required to hold it.

Test Plan:
- lw: rs1=0x1000, imm=4, memory word 0xDEADBEEF -> REQ addr 0x1004, rmask 1111; response after 2 cycles; cdb_data 0xDEADBEEF, valid 1 cycle.
- lb/lbu: rs1=0x2003, imm=0, rdata 0x80xxxxxx -> rmask 1000; lb gives 0xFFFFFF80, lbu gives 0x00000080.
- sh: rs1=0x3000, imm=2, rs2=0x1234ABCD -> wmask 1100, wdata 0xABCD0000; cdb_is_store=1, cdb_data=0.
- Flush while in WAIT, response 3 cycles later -> stall_mem stays 1 through the response; no cdb_valid; next packet is accepted the cycle after.
- Back-to-back: pkt_valid held continuously -> second packet is accepted only in the cycle after the first cdb result, with stall_mem=1 throughout the first packet's occupancy.
- Drop rst low in WAIT -> all outputs are 0 immediately (asynchronously); a late dmem_resp after reset is ignored and produces no CDB pulse.
